// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Collects completed results from the reservation stations (memory, adder,
// multiplier) into one holding slot per source. A round-robin arbiter then
// broadcasts one held result per cycle on the registered common data bus.
//
// Ports
//   clk            clock
//   reset          synchronous, active-high reset
//   en_i           global enable; all state frozen while low
//   src_valid_i    per-source result-present strobe
//   src_data_i     flattened results, source k at [k*DATA_W +: DATA_W]
//   src_tag_i      flattened tags, source k at [k*TAG_W +: TAG_W]
//   src_ack_o      combinational accept, result taken at this clock edge
//   cdb_valid_o    registered broadcast valid
//   cdb_data_o     registered broadcast data
//   cdb_tag_o      registered broadcast tag
//   err_bad_tag_o  registered one-cycle pulse when a tag_valid==0 result is dropped
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int NUM_SRC = 3,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en_i,
    input  logic [NUM_SRC-1:0]        src_valid_i,
    input  logic [NUM_SRC*DATA_W-1:0] src_data_i,
    input  logic [NUM_SRC*TAG_W-1:0]  src_tag_i,
    output logic [NUM_SRC-1:0]        src_ack_o,
    output logic                      cdb_valid_o,
    output logic [DATA_W-1:0]         cdb_data_o,
    output logic [TAG_W-1:0]          cdb_tag_o,
    output logic                      err_bad_tag_o
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // Holding slots
    logic [NUM_SRC-1:0] full_q, full_d;
    logic [DATA_W-1:0]  data_q [NUM_SRC];
    logic [DATA_W-1:0]  data_d [NUM_SRC];
    logic [TAG_W-1:0]   tag_q  [NUM_SRC];
    logic [TAG_W-1:0]   tag_d  [NUM_SRC];

    // Arbitration pointer and broadcast registers
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               cdb_valid_q, cdb_valid_d;
    logic [DATA_W-1:0]  cdb_data_q, cdb_data_d;
    logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
    logic               err_q, err_d;

    // Grant
    logic [NUM_SRC-1:0] grant_s;
    logic [PTR_W-1:0]   grant_idx_s;
    logic               any_grant_s;
    logic [PTR_W-1:0]   cand_s;

    // Round-robin search: first full slot at or after rr_ptr, wrapping.
    always_comb begin
        grant_s     = '0;
        grant_idx_s = '0;
        any_grant_s = 1'b0;
        cand_s      = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand_s = PTR_W'((int'(rr_ptr_q) + i) % NUM_SRC);
            if (!any_grant_s && full_q[cand_s]) begin
                grant_s[cand_s] = 1'b1;
                grant_idx_s     = cand_s;
                any_grant_s     = 1'b1;
            end else begin
                any_grant_s = any_grant_s;
            end
        end
    end

    // Accept a result when its slot is empty or being drained this cycle.
    always_comb begin
        src_ack_o = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            src_ack_o[k] = en_i & src_valid_i[k] & (~full_q[k] | grant_s[k]);
        end
    end

    // Next-state: broadcast the granted slot, then load acked results.
    always_comb begin
        full_d      = full_q;
        data_d      = data_q;
        tag_d       = tag_q;
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = cdb_valid_q;
        cdb_data_d  = cdb_data_q;
        cdb_tag_d   = cdb_tag_q;
        err_d       = err_q;
        if (en_i) begin
            if (any_grant_s) begin
                cdb_valid_d          = 1'b1;
                cdb_data_d           = data_q[grant_idx_s];
                cdb_tag_d            = tag_q[grant_idx_s];
                full_d[grant_idx_s]  = 1'b0;
                rr_ptr_d = (grant_idx_s == PTR_W'(NUM_SRC - 1)) ? '0
                                                                 : grant_idx_s + PTR_W'(1);
            end else begin
                cdb_valid_d = 1'b0;
                cdb_data_d  = '0;
                cdb_tag_d   = '0;
            end
            err_d = 1'b0;
            // A refill here overrides the clear of a just-granted slot.
            for (int k = 0; k < NUM_SRC; k++) begin
                if (src_ack_o[k]) begin
                    if (src_tag_i[k*TAG_W + TAG_W - 1]) begin
                        full_d[k] = 1'b1;
                        data_d[k] = src_data_i[k*DATA_W +: DATA_W];
                        tag_d[k]  = src_tag_i[k*TAG_W +: TAG_W];
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    full_d[k] = full_d[k];
                end
            end
        end else begin
            err_d = err_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q      <= '0;
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_data_q  <= '0;
            cdb_tag_q   <= '0;
            err_q       <= 1'b0;
            for (int k = 0; k < NUM_SRC; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            full_q      <= full_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_data_q  <= cdb_data_d;
            cdb_tag_q   <= cdb_tag_d;
            err_q       <= err_d;
            for (int k = 0; k < NUM_SRC; k++) begin
                data_q[k] <= data_d[k];
                tag_q[k]  <= tag_d[k];
            end
        end
    end

    assign cdb_valid_o   = cdb_valid_q;
    assign cdb_data_o    = cdb_data_q;
    assign cdb_tag_o     = cdb_tag_q;
    assign err_bad_tag_o = err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter: directed scenarios plus a randomized run against a
// slot/pointer reference model of the CDB arbiter.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

    logic        clk;
    logic        reset;
    logic        en;
    logic [2:0]  src_valid;
    logic [95:0] src_data;
    logic [23:0] src_tag;
    logic [2:0]  src_ack;
    logic        cdb_valid;
    logic [31:0] cdb_data;
    logic [7:0]  cdb_tag;
    logic        err_bad_tag;

    int total = 0;
    int bad   = 0;

    cdb_arbiter #(.NUM_SRC(3), .DATA_W(32), .TAG_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .en_i         (en),
        .src_valid_i  (src_valid),
        .src_data_i   (src_data),
        .src_tag_i    (src_tag),
        .src_ack_o    (src_ack),
        .cdb_valid_o  (cdb_valid),
        .cdb_data_o   (cdb_data),
        .cdb_tag_o    (cdb_tag),
        .err_bad_tag_o(err_bad_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; src_valid = 3'b000; src_data = '0; src_tag = '0;
        tick(); tick();
        total++;
        if ({cdb_valid, cdb_tag, cdb_data, err_bad_tag} !== 42'h0) begin
            bad++;
            $display("FAIL reset_outputs got v=%b t=%h d=%h e=%b exp all zero",
                     cdb_valid, cdb_tag, cdb_data, err_bad_tag);
        end
        reset = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({cdb_valid, cdb_tag} !== 9'h000) begin
                bad++;
                $display("FAIL idle_cycle%0d got v=%b t=%h exp v=0 t=00", i, cdb_valid, cdb_tag);
            end
        end
    endtask

    task automatic test_single();
        src_valid = 3'b100; src_data[64 +: 32] = 32'h0000_0F00; src_tag[16 +: 8] = 8'h91;
        #1;
        total++;
        if (src_ack !== 3'b100) begin
            bad++; $display("FAIL single_ack got=%b exp=100", src_ack);
        end
        tick();
        src_valid = 3'b000;
        total++;
        if (cdb_valid !== 1'b0) begin
            bad++; $display("FAIL single_early got v=%b exp v=0", cdb_valid);
        end
        tick();
        total++;
        if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, 8'h91, 32'h0000_0F00}) begin
            bad++;
            $display("FAIL single_bcast got v=%b t=%h d=%h exp v=1 t=91 d=00000f00",
                     cdb_valid, cdb_tag, cdb_data);
        end
        tick();
        total++;
        if (cdb_valid !== 1'b0) begin
            bad++; $display("FAIL single_oneshot got v=%b exp v=0", cdb_valid);
        end
    endtask

    task automatic test_contention();
        logic [7:0]  exp_t [4];
        logic [31:0] exp_d [4];
        exp_t[0] = 8'hC0; exp_t[1] = 8'hA0; exp_t[2] = 8'h90; exp_t[3] = 8'hC1;
        exp_d[0] = 32'h100; exp_d[1] = 32'h200; exp_d[2] = 32'h300; exp_d[3] = 32'h101;
        src_valid = 3'b111;
        src_tag   = {8'h90, 8'hA0, 8'hC0};
        src_data  = {32'h300, 32'h200, 32'h100};
        #1;
        total++;
        if (src_ack !== 3'b111) begin
            bad++; $display("FAIL cont_ack got=%b exp=111", src_ack);
        end
        tick();
        src_valid = 3'b000;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) begin
                // source 0 comes back right after its grant
                src_valid = 3'b001; src_tag[7:0] = 8'hC1; src_data[31:0] = 32'h101;
                #1;
                total++;
                if (src_ack !== 3'b001) begin
                    bad++; $display("FAIL cont_reack got=%b exp=001", src_ack);
                end
            end else if (i == 1) begin
                src_valid = 3'b000;
            end
            total++;
            if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, exp_t[i], exp_d[i]}) begin
                bad++;
                $display("FAIL cont_order%0d got v=%b t=%h d=%h exp v=1 t=%h d=%h",
                         i, cdb_valid, cdb_tag, cdb_data, exp_t[i], exp_d[i]);
            end
        end
        tick();
        total++;
        if (cdb_valid !== 1'b0) begin
            bad++; $display("FAIL cont_drained got v=%b exp v=0", cdb_valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            src_valid = 3'b010; src_tag[15:8] = 8'hA3; src_data[63:32] = 32'(i + 1);
            #1;
            total++;
            if (src_ack !== 3'b010) begin
                bad++; $display("FAIL b2b_ack%0d got=%b exp=010", i, src_ack);
            end
            tick();
            if (i > 0) begin
                total++;
                if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, 8'hA3, 32'(i)}) begin
                    bad++;
                    $display("FAIL b2b_bcast%0d got v=%b t=%h d=%h exp v=1 t=a3 d=%0d",
                             i, cdb_valid, cdb_tag, cdb_data, i);
                end
            end
        end
        src_valid = 3'b000;
        tick();
        total++;
        if ({cdb_valid, cdb_data} !== {1'b1, 32'd4}) begin
            bad++; $display("FAIL b2b_last got v=%b d=%h exp v=1 d=4", cdb_valid, cdb_data);
        end
        tick();
        total++;
        if (cdb_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_end got v=%b exp v=0", cdb_valid);
        end
    endtask

    task automatic test_bad_tag();
        src_valid = 3'b010; src_tag[15:8] = 8'h23; src_data[63:32] = 32'hDEAD;
        #1;
        total++;
        if (src_ack !== 3'b010) begin
            bad++; $display("FAIL badtag_ack got=%b exp=010", src_ack);
        end
        tick();
        src_valid = 3'b000;
        total++;
        if ({err_bad_tag, cdb_valid} !== 2'b10) begin
            bad++; $display("FAIL badtag_pulse got e=%b v=%b exp e=1 v=0", err_bad_tag, cdb_valid);
        end
        tick();
        total++;
        if ({err_bad_tag, cdb_valid} !== 2'b00) begin
            bad++; $display("FAIL badtag_clear got e=%b v=%b exp e=0 v=0", err_bad_tag, cdb_valid);
        end
    endtask

    task automatic test_freeze_reset();
        src_valid = 3'b100; src_tag[23:16] = 8'h92; src_data[95:64] = 32'hAAAA;
        tick();
        // second result refills slot 2 on the edge that broadcasts the first
        src_tag[23:16] = 8'h93; src_data[95:64] = 32'hBBBB;
        #1;
        total++;
        if (src_ack !== 3'b100) begin
            bad++; $display("FAIL frz_refill_ack got=%b exp=100", src_ack);
        end
        tick();
        en = 1'b0; src_valid = 3'b111; src_tag[23:16] = 8'h94;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({src_ack, cdb_valid, cdb_tag, cdb_data, err_bad_tag} !==
                {3'b000, 1'b1, 8'h92, 32'hAAAA, 1'b0}) begin
                bad++;
                $display("FAIL frz_hold%0d got a=%b v=%b t=%h d=%h e=%b exp a=000 v=1 t=92 d=aaaa e=0",
                         i, src_ack, cdb_valid, cdb_tag, cdb_data, err_bad_tag);
            end
            tick();
        end
        en = 1'b1; reset = 1'b1; src_valid = 3'b000;
        tick();
        reset = 1'b0;
        total++;
        if ({cdb_valid, cdb_tag, cdb_data} !== 41'h0) begin
            bad++;
            $display("FAIL frz_reset got v=%b t=%h d=%h exp zero", cdb_valid, cdb_tag, cdb_data);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (cdb_valid !== 1'b0) begin
                bad++; $display("FAIL frz_stale%0d got v=%b t=%h exp v=0", i, cdb_valid, cdb_tag);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] q_d [3][$];
        logic [7:0]  q_t [3][$];
        bit          m_full [3];
        logic [31:0] m_data [3];
        logic [7:0]  m_tag  [3];
        int          m_ptr;
        int          g;
        logic [2:0]  exp_ack;
        logic        e_v, e_err;
        logic [31:0] e_d;
        logic [7:0]  e_t;

        reset = 1'b1; en = 1'b0; src_valid = 3'b000;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_full[k] = 1'b0; m_data[k] = '0; m_tag[k] = '0;
        end
        m_ptr = 0; e_v = 1'b0; e_d = '0; e_t = '0; e_err = 1'b0;

        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (q_d[k].size() < 4 && $urandom_range(0, 1) == 1) begin
                    q_d[k].push_back($urandom());
                    q_t[k].push_back(($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 127))
                                                                  : 8'($urandom_range(128, 255)));
                end
            end
            en = ($urandom_range(0, 9) != 0);
            for (int k = 0; k < 3; k++) begin
                src_valid[k] = (q_d[k].size() > 0);
                src_data[k*32 +: 32] = src_valid[k] ? q_d[k][0] : 32'h0;
                src_tag[k*8 +: 8]    = src_valid[k] ? q_t[k][0] : 8'h0;
            end
            // first full slot starting from the pointer, wrapping
            g = -1;
            for (int i = 0; i < 3; i++) begin
                if (g < 0 && m_full[(m_ptr + i) % 3]) g = (m_ptr + i) % 3;
            end
            for (int k = 0; k < 3; k++) begin
                exp_ack[k] = en && src_valid[k] && (!m_full[k] || g == k);
            end
            #1;
            total++;
            if (src_ack !== exp_ack) begin
                bad++; $display("FAIL rnd_ack c=%0d got=%b exp=%b", c, src_ack, exp_ack);
            end
            @(posedge clk);
            if (en) begin
                if (g >= 0) begin
                    e_v = 1'b1; e_d = m_data[g]; e_t = m_tag[g];
                    m_full[g] = 1'b0; m_ptr = (g + 1) % 3;
                end else begin
                    e_v = 1'b0; e_d = '0; e_t = '0;
                end
                e_err = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    if (exp_ack[k]) begin
                        if (q_t[k][0][7]) begin
                            m_full[k] = 1'b1; m_data[k] = q_d[k][0]; m_tag[k] = q_t[k][0];
                        end else begin
                            e_err = 1'b1;
                        end
                        void'(q_d[k].pop_front());
                        void'(q_t[k].pop_front());
                    end
                end
            end
            #1;
            total++;
            if ({cdb_valid, cdb_tag, cdb_data, err_bad_tag} !== {e_v, e_t, e_d, e_err}) begin
                bad++;
                $display("FAIL rnd_out c=%0d got v=%b t=%h d=%h e=%b exp v=%b t=%h d=%h e=%b",
                         c, cdb_valid, cdb_tag, cdb_data, err_bad_tag, e_v, e_t, e_d, e_err);
            end
        end
        src_valid = 3'b000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_bad_tag();
        test_freeze_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
